// File: rtl/knapsack_search_if.sv
// Handshake/result bundle for knapsack_search: request side, output slot and search results.
interface knapsack_search_if;
    logic        start;
    logic [7:0]  min_value;
    logic [7:0]  max_weight;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_sel;
    logic        done;
    logic [5:0]  count;
    logic [10:0] best_value;
    logic [4:0]  best_sel;

    modport master (
        output start, min_value, max_weight, out_ready,
        input  busy, out_valid, out_sel, done, count, best_value, best_sel
    );

    modport slave (
        input  start, min_value, max_weight, out_ready,
        output busy, out_valid, out_sel, done, count, best_value, best_sel
    );
endinterface

// File: rtl/knapsack_search.sv
// Exhaustive 5-item knapsack search: streams every feasible selection in index order.
// Optional best-value tracking is enabled by defining KNAPSACK_BEST_TRACK_EN.
module knapsack_search #(
    parameter logic [7:0] V_A = 8'd4,
    parameter logic [7:0] V_B = 8'd2,
    parameter logic [7:0] V_C = 8'd2,
    parameter logic [7:0] V_D = 8'd1,
    parameter logic [7:0] V_E = 8'd10,
    parameter logic [7:0] W_A = 8'd12,
    parameter logic [7:0] W_B = 8'd1,
    parameter logic [7:0] W_C = 8'd2,
    parameter logic [7:0] W_D = 8'd1,
    parameter logic [7:0] W_E = 8'd4
) (
    input logic              clk,
    input logic              rst,
    knapsack_search_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t      state;
    logic [5:0]  idx;
    logic [7:0]  min_q;
    logic [7:0]  maxw_q;
    logic        busy_r;
    logic        done_r;
    logic        out_valid_r;
    logic [4:0]  out_sel_r;
    logic [5:0]  count_r;
    logic [4:0]  cand;
    logic [10:0] tot_v;
    logic [10:0] tot_w;
    logic        feasible;
    logic        slot_free;

    function automatic logic [10:0] pick(input logic bit_set, input logic [7:0] x);
        return bit_set ? {3'b000, x} : 11'd0;
    endfunction

    always_comb begin
        cand      = idx[4:0];
        tot_v     = pick(cand[0], V_A) + pick(cand[1], V_B) + pick(cand[2], V_C)
                  + pick(cand[3], V_D) + pick(cand[4], V_E);
        tot_w     = pick(cand[0], W_A) + pick(cand[1], W_B) + pick(cand[2], W_C)
                  + pick(cand[3], W_D) + pick(cand[4], W_E);
        feasible  = (tot_v >= {3'b000, min_q}) && (tot_w <= {3'b000, maxw_q});
        slot_free = !out_valid_r || bus.out_ready;
    end

`ifdef KNAPSACK_BEST_TRACK_EN
    logic [10:0] best_value_r;
    logic [4:0]  best_sel_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_value_r <= '0;
            best_sel_r   <= '0;
        end else if (state == IDLE && bus.start) begin
            best_value_r <= '0;
            best_sel_r   <= '0;
        end else if (state == SCAN && !idx[5] && slot_free && feasible && tot_v > best_value_r) begin
            best_value_r <= tot_v;
            best_sel_r   <= cand;
        end
    end

    assign bus.best_value = best_value_r;
    assign bus.best_sel   = best_sel_r;
`else
    assign bus.best_value = '0;
    assign bus.best_sel   = '0;
`endif

    // idx[5] marks "all 32 candidates evaluated"; that cycle only retires the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            min_q       <= '0;
            maxw_q      <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_sel_r   <= '0;
            count_r     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= SCAN;
                        busy_r  <= 1'b1;
                        idx     <= '0;
                        count_r <= '0;
                        min_q   <= bus.min_value;
                        maxw_q  <= bus.max_weight;
                    end
                end
                SCAN: begin
                    if (idx[5]) begin
                        state <= DRAIN;
                        if (bus.out_ready) out_valid_r <= 1'b0;
                    end else if (slot_free) begin
                        idx <= idx + 6'd1;
                        if (feasible) begin
                            out_sel_r   <= cand;
                            out_valid_r <= 1'b1;
                            count_r     <= count_r + 6'd1;
                        end else begin
                            out_valid_r <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (slot_free) begin
                        state       <= DONE;
                        done_r      <= 1'b1;
                        out_valid_r <= 1'b0;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_sel   = out_sel_r;
    assign bus.count     = count_r;

endmodule
